// File: rtl/rx_loop_ctrl.sv
// Multi-frame receive controller: enables the rx core, counts END events, handles abort and inactivity timeout.
// Optional error-event counting is enabled by defining RX_LOOP_ERR_CNT_EN.
`ifndef RX_EVENT_END
`define RX_EVENT_END 3'd1
`endif

module rx_loop_ctrl #(
    parameter int              EV_W   = 3,
    parameter logic [EV_W-1:0] EV_END = `RX_EVENT_END,
    parameter logic [EV_W-1:0] EV_ERR = 3'd7,
    parameter int              CNT_W  = 16,
    parameter int              TO_W   = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic [CNT_W-1:0] i_num_frames,
    input  logic [TO_W-1:0]  i_timeout,
    input  logic [EV_W-1:0]  i_ev,
    input  logic             i_ev_sig,
    output logic             o_rx_enable,
    output logic             o_busy,
    output logic             o_frame_done,
    output logic [CNT_W-1:0] o_frame_cnt,
    output logic             o_done,
    output logic [1:0]       o_status,
    output logic [CNT_W-1:0] o_err_cnt
);

    typedef enum logic [1:0] {S_IDLE, S_START, S_RUN, S_STOP} state_t;

    localparam logic [1:0]      ST_NONE  = 2'd0;
    localparam logic [1:0]      ST_COUNT = 2'd1;
    localparam logic [1:0]      ST_TMO   = 2'd2;
    localparam logic [1:0]      ST_ABORT = 2'd3;
    localparam logic [TO_W-1:0] TO_ONE   = TO_W'(1);

`ifdef RX_LOOP_ERR_CNT_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    function automatic logic [TO_W-1:0] sat_inc_to(input logic [TO_W-1:0] v);
        return (&v) ? v : v + TO_ONE;
    endfunction

    state_t           state;
    logic [CNT_W-1:0] num_lat;
    logic [TO_W-1:0]  to_lat;
    logic [TO_W-1:0]  to_cnt;
    logic [CNT_W-1:0] err_cnt;

    logic             ev_end;
    logic             ev_err;
    logic [CNT_W-1:0] cnt_next;
    logic             cnt_hit;
    logic             to_expired;

    assign ev_end     = i_ev_sig && (i_ev == EV_END);
    assign ev_err     = ERR_EN && i_ev_sig && (i_ev == EV_ERR);
    assign cnt_next   = sat_inc_cnt(o_frame_cnt);
    assign cnt_hit    = (num_lat != '0) && (cnt_next == num_lat);
    // Expiry one count early so STOP is entered exactly i_timeout quiet cycles after the last event.
    assign to_expired = (to_lat != '0) && (to_cnt == to_lat - TO_ONE);
    assign o_err_cnt  = err_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            o_rx_enable  <= 1'b0;
            o_busy       <= 1'b0;
            o_frame_done <= 1'b0;
            o_frame_cnt  <= '0;
            o_done       <= 1'b0;
            o_status     <= ST_NONE;
            num_lat      <= '0;
            to_lat       <= '0;
            to_cnt       <= '0;
            err_cnt      <= '0;
        end else begin
            o_frame_done <= 1'b0;
            o_done       <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (i_start) begin
                        num_lat     <= i_num_frames;
                        to_lat      <= i_timeout;
                        o_frame_cnt <= '0;
                        o_status    <= ST_NONE;
                        to_cnt      <= '0;
                        err_cnt     <= '0;
                        o_busy      <= 1'b1;
                        state       <= S_START;
                    end
                end
                S_START: begin
                    o_rx_enable <= 1'b1;
                    o_busy      <= 1'b1;
                    state       <= S_RUN;
                end
                S_RUN: begin
                    if (ev_err) begin
                        err_cnt <= sat_inc_cnt(err_cnt);
                    end
                    if (ev_end) begin
                        o_frame_cnt  <= cnt_next;
                        o_frame_done <= 1'b1;
                        to_cnt       <= '0;
                        if (cnt_hit) begin
                            o_status <= ST_COUNT;
                            state    <= S_STOP;
                        end else if (i_abort) begin
                            o_status <= ST_ABORT;
                            state    <= S_STOP;
                        end
                    end else if (i_ev_sig) begin
                        to_cnt <= '0;
                        if (i_abort) begin
                            o_status <= ST_ABORT;
                            state    <= S_STOP;
                        end
                    end else if (i_abort) begin
                        o_status <= ST_ABORT;
                        state    <= S_STOP;
                    end else if (to_expired) begin
                        o_status <= ST_TMO;
                        state    <= S_STOP;
                    end else begin
                        to_cnt <= sat_inc_to(to_cnt);
                    end
                end
                S_STOP: begin
                    o_rx_enable <= 1'b0;
                    o_busy      <= 1'b0;
                    o_done      <= 1'b1;
                    state       <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rx_loop_ctrl.sv
// Scoreboard bench for rx_loop_ctrl: expected frame/done results are queued as events are driven
// and compared when o_frame_done / o_done fire. Built with CNT_W=4 to exercise count saturation.
module tb_rx_loop_ctrl;

    localparam int         EV_W   = 3;
    localparam int         CNT_W  = 4;
    localparam int         TO_W   = 24;
    localparam logic [2:0] EV_END = 3'd1;
    localparam logic [2:0] EV_ERR = 3'd7;
    localparam logic [2:0] EV_OTH = 3'd2;

    logic             clk = 1'b0;
    logic             reset;
    logic             i_start;
    logic             i_abort;
    logic [CNT_W-1:0] i_num_frames;
    logic [TO_W-1:0]  i_timeout;
    logic [EV_W-1:0]  i_ev;
    logic             i_ev_sig;
    logic             o_rx_enable;
    logic             o_busy;
    logic             o_frame_done;
    logic [CNT_W-1:0] o_frame_cnt;
    logic             o_done;
    logic [1:0]       o_status;
    logic [CNT_W-1:0] o_err_cnt;

    rx_loop_ctrl #(
        .EV_W(EV_W), .EV_END(EV_END), .EV_ERR(EV_ERR), .CNT_W(CNT_W), .TO_W(TO_W)
    ) dut (
        .clk(clk), .reset(reset), .i_start(i_start), .i_abort(i_abort),
        .i_num_frames(i_num_frames), .i_timeout(i_timeout), .i_ev(i_ev), .i_ev_sig(i_ev_sig),
        .o_rx_enable(o_rx_enable), .o_busy(o_busy), .o_frame_done(o_frame_done),
        .o_frame_cnt(o_frame_cnt), .o_done(o_done), .o_status(o_status), .o_err_cnt(o_err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]       status;
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] err;
    } done_t;

    done_t            done_q[$];
    logic [CNT_W-1:0] fd_q[$];
    done_t            d_exp;
    int               n_chk = 0;
    int               n_err = 0;
    int               fd_seen = 0;
    int               done_seen = 0;
    logic [CNT_W-1:0] exp_cnt;
    logic [CNT_W-1:0] exp_err;
    logic [CNT_W-1:0] cur_num;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s got %0d want %0d", tag, obs, exp);
        end
    endtask

    // Output monitor: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (o_frame_done === 1'b1) begin
            fd_seen++;
            if (fd_q.size() == 0) chk("spur_fd", o_frame_done, 0);
            else chk("fd_cnt", o_frame_cnt, fd_q.pop_front());
        end
        if (o_done === 1'b1) begin
            done_seen++;
            if (done_q.size() == 0) begin
                chk("spur_done", o_done, 0);
            end else begin
                d_exp = done_q.pop_front();
                chk("done_status", o_status, d_exp.status);
                chk("done_cnt", o_frame_cnt, d_exp.cnt);
                chk("done_err", o_err_cnt, d_exp.err);
                chk("done_rxen", o_rx_enable, 0);
                chk("done_busy", o_busy, 0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic start_run(input logic [CNT_W-1:0] num, input logic [TO_W-1:0] to);
        i_num_frames = num;
        i_timeout    = to;
        cur_num      = num;
        exp_cnt      = '0;
        exp_err      = '0;
        i_start      = 1'b1;
        tick();
        i_start = 1'b0;
        chk("st_status", o_status, 0);
        chk("st_cnt", o_frame_cnt, 0);
        chk("st_en0", o_rx_enable, 0);
        chk("st_busy", o_busy, 1);
        tick();
        chk("st_en1", o_rx_enable, 1);
    endtask

    task automatic send_ev(input logic [2:0] code, input logic abort);
        if (code == EV_END) begin
            if (exp_cnt != {CNT_W{1'b1}}) exp_cnt = exp_cnt + 1'b1;
            fd_q.push_back(exp_cnt);
        end
`ifdef RX_LOOP_ERR_CNT_EN
        if (code == EV_ERR && exp_err != {CNT_W{1'b1}}) exp_err = exp_err + 1'b1;
`endif
        if (code == EV_END && cur_num != 0 && exp_cnt == cur_num)
            done_q.push_back(done_t'{status: 2'd1, cnt: exp_cnt, err: exp_err});
        else if (abort)
            done_q.push_back(done_t'{status: 2'd3, cnt: exp_cnt, err: exp_err});
        i_ev     = code;
        i_ev_sig = 1'b1;
        i_abort  = abort;
        tick();
        i_ev_sig = 1'b0;
        i_abort  = 1'b0;
        i_ev     = '0;
    endtask

    // Leaves the caller just after the edge that raised o_done.
    task automatic wait_done(input int budget, input string tag);
        for (int i = 0; i < budget; i++) begin
            tick();
            if (o_done === 1'b1) return;
        end
        chk(tag, o_done, 1);
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int base_fd;
        int base_done;
        reset = 1'b1;
        i_start = 0; i_abort = 0; i_num_frames = '0; i_timeout = '0; i_ev = '0; i_ev_sig = 0;
        cur_num = '0; exp_cnt = '0; exp_err = '0;
        idle(3);
        chk("rst_rxen", o_rx_enable, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_fd", o_frame_done, 0);
        chk("rst_cnt", o_frame_cnt, 0);
        chk("rst_done", o_done, 0);
        chk("rst_status", o_status, 0);
        chk("rst_err", o_err_cnt, 0);
        reset = 1'b0;
        idle(2);

        // Counted run: three END events ten cycles apart.
        start_run(3, 0);
        for (int k = 0; k < 3; k++) begin
            idle(9);
            send_ev(EV_END, 1'b0);
        end
        wait_done(10, "t1_done_to");
        idle(3);
        chk("t1_hold_status", o_status, 1);
        chk("t1_hold_cnt", o_frame_cnt, 3);
        // Abort and events while idle must be ignored.
        i_abort = 1'b1;
        idle(2);
        i_abort = 1'b0;
        i_ev = EV_END; i_ev_sig = 1'b1;
        tick();
        i_ev_sig = 1'b0;
        idle(2);
        chk("idle_busy", o_busy, 0);
        chk("idle_status", o_status, 1);
        chk("idle_cnt", o_frame_cnt, 3);

        // Continuous mode with timeout 100: one END then silence.
        start_run(0, 100);
        idle(4);
        send_ev(EV_END, 1'b0);
        done_q.push_back(done_t'{status: 2'd2, cnt: 4'd1, err: exp_err});
        n = 0;
        // STOP is entered 100 cycles after the END edge; o_done rises one edge later.
        for (int i = 0; i < 300; i++) begin
            n++;
            tick();
            if (o_done === 1'b1) break;
        end
        chk("to_latency", n, 101);
        idle(2);

        // END + abort together at frame 2 -> abort status.
        start_run(5, 0);
        send_ev(EV_END, 1'b0);
        idle(3);
        send_ev(EV_END, 1'b1);
        wait_done(10, "t3a_done_to");
        // Restart in the cycle o_done is high; END + abort on frame 5 -> count reached.
        start_run(5, 0);
        for (int k = 0; k < 4; k++) begin
            send_ev(EV_END, 1'b0);
            idle(2);
        end
        send_ev(EV_END, 1'b1);
        wait_done(10, "t3b_done_to");

        // Non-END events every 40 cycles keep a 50-cycle timeout from expiring.
        start_run(2, 50);
        for (int k = 0; k < 10; k++) begin
            idle(39);
            send_ev(EV_OTH, 1'b0);
            if (k == 4) begin
                i_num_frames = 1; i_start = 1'b1;
                tick();
                i_start = 1'b0;
                chk("busy_start_ign", o_busy, 1);
            end
        end
        chk("t4_busy", o_busy, 1);
        chk("t4_cnt", o_frame_cnt, 0);
        chk("t4_status", o_status, 0);
        send_ev(EV_OTH, 1'b1);
        wait_done(10, "t4_done_to");
        idle(2);

        // Continuous count saturation, then reset mid-run.
        base_fd = fd_seen;
        start_run(0, 0);
        for (int k = 0; k < 20; k++) begin
            send_ev(EV_END, 1'b0);
            tick();
        end
        tick();
        chk("sat_fd_n", fd_seen - base_fd, 20);
        chk("sat_cnt", o_frame_cnt, 15);
        chk("sat_busy", o_busy, 1);
        base_done = done_seen;
        reset = 1'b1;
        #1;
        chk("arst_rxen", o_rx_enable, 0);
        chk("arst_busy", o_busy, 0);
        chk("arst_cnt", o_frame_cnt, 0);
        chk("arst_status", o_status, 0);
        idle(2);
        reset = 1'b0;
        idle(5);
        chk("arst_no_done", done_seen - base_done, 0);

        // Error events then completion.
        start_run(1, 0);
        for (int k = 0; k < 4; k++) begin
            send_ev(EV_ERR, 1'b0);
            idle(2);
        end
`ifdef RX_LOOP_ERR_CNT_EN
        chk("err_cnt", o_err_cnt, 4);
`else
        chk("err_cnt", o_err_cnt, 0);
`endif
        send_ev(EV_END, 1'b0);
        wait_done(10, "t6_done_to");
        idle(3);

        chk("fd_q_empty", fd_q.size(), 0);
        chk("done_q_empty", done_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
